uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
- Sequences the UART receive path. Consumes bytes from the uart_rcv byte interface (rx_rdy/rx_data/clr_rx_rdy) and assembles each pair into a 16-bit command, high byte first.
- Presents the command to the downstream command processor with a ready/clear handshake.
- Provides an inter-byte timeout for resynchronisation and flags overrun and framing errors.

Parameters:
TIMEOUT_CYCLES, 100000, clk cycles allowed between high-byte accept and low-byte accept before the partial command is discarded (must be >= 2)
TO_W, 17, width of timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rx_rdy  input  1  byte-valid level from uart_rcv; may stay high many cycles per byte
rx_data  input  8  received byte from uart_rcv; valid while rx_rdy high
clr_rx_rdy  output  1  one-cycle pulse acknowledging an accepted byte
cmd  output  16  assembled command {high_byte, low_byte}
cmd_rdy  output  1  high while an unconsumed command is held in cmd
clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy and overrun
overrun  output  1  sticky: a new command completed while cmd_rdy was still high
frm_err  output  1  one-cycle pulse: partial command discarded on timeout

Behaviour:
- Reset values (async, rst_n low): cmd=16'h0000, cmd_rdy=0, overrun=0, frm_err=0, clr_rx_rdy=0, state=IDLE, high-byte register=8'h00, timeout counter=0, rx_rdy_q=0.
- Byte accept:
  - rx_rdy_q is a registered copy of rx_rdy.
  - A byte is accepted only on a rising edge (rx_rdy=1 and rx_rdy_q=0).
  - A level held high never yields a second accept.
  - rx_rdy_q resets to 0, so rx_rdy high out of reset counts as a rising edge on the first cycle.
  - clr_rx_rdy is registered and pulses exactly one cycle, in the cycle after each accept.
- State machine, 2 states:
  - IDLE: on accept, latch rx_data into the high-byte register, clear the timeout counter, go to WAIT_LO.
  - WAIT_LO, on accept: set cmd <= {high_byte, rx_data} and cmd_rdy <= 1 in the same clock edge, go to IDLE. Latency is 1 clock from rx_rdy rising to cmd_rdy high.
  - WAIT_LO, no accept: increment the timeout counter. When the counter equals TIMEOUT_CYCLES-1 (and there is no accept that cycle), pulse frm_err for one cycle, go to IDLE, and discard the high byte. cmd and cmd_rdy are untouched.
  - WAIT_LO, accept and timeout in the same cycle: the accept wins; the command completes and there is no frm_err.
- cmd_rdy:
  - Set on command completion.
  - Cleared on clr_cmd_rdy.
  - If completion and clr_cmd_rdy occur in the same cycle, completion wins: cmd_rdy stays 1 with the new cmd.
  - cmd holds its value after cmd_rdy clears; it changes only on completion.
- overrun:
  - Set when a completion occurs while cmd_rdy=1 and clr_cmd_rdy=0. cmd is overwritten with the new value.
  - Cleared by clr_cmd_rdy. When set and clear coincide, clear wins, since the consumer read the old value in that cycle.
- Timeout counter: TO_W bits, counts only in WAIT_LO, never wraps (bounded by TIMEOUT_CYCLES-1).
- Reset mid-operation: asynchronous return to the reset values above. A partial high byte is lost; any rx_rdy level still high after reset release is treated as a fresh byte (rx_rdy_q=0).
- Not required: parity, byte escapes, or a command FIFO. Depth is one command.

Test Plan:
- Two bytes 8'hA5 then 8'h3C, each rx_rdy held 2604 cycles, gaps of 20000 cycles -> exactly two clr_rx_rdy pulses; cmd=16'hA53C and cmd_rdy=1 one clk after the second rx_rdy rise; overrun=0; frm_err=0.
- Assert clr_cmd_rdy for 1 cycle after the previous step -> cmd_rdy=0 next clk; cmd stays 16'hA53C.
- High byte 8'h12, then no byte for TIMEOUT_CYCLES (set to 50 in bench) -> single frm_err pulse, state IDLE. Then bytes 8'h34, 8'h56 -> cmd=16'h3456 (8'h12 discarded).
- Complete 16'h1111 without clearing, then 16'h2222 -> cmd=16'h2222, cmd_rdy=1, overrun=1. Then clr_cmd_rdy -> cmd_rdy=0, overrun=0.
- Second-byte completion coincident with a clr_cmd_rdy pulse -> cmd_rdy remains 1, overrun=0. Separately, low-byte rx_rdy rising on the exact timeout cycle -> command completes, no frm_err.
- Assert rst_n low in WAIT_LO after high byte 8'hFF, release, send 8'h01, 8'h02 -> cmd=16'h0102; all outputs zero during reset.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
//   Sequences the UART receive path. Accepts bytes from the uart_rcv byte
//   interface on rising edges of rx_rdy and pairs them into 16-bit commands,
//   high byte first. Each command is presented to the downstream command
//   processor with a ready/clear handshake. An inter-byte timeout discards a
//   lone high byte so the stream can resynchronise.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx_rdy       byte-valid level from uart_rcv (may stay high many cycles)
//   rx_data      received byte, valid while rx_rdy is high
//   clr_rx_rdy   one-cycle acknowledge, in the cycle after a byte is accepted
//   cmd          assembled command {high_byte, low_byte}
//   cmd_rdy      an unconsumed command is held in cmd
//   clr_cmd_rdy  consumer acknowledge; clears cmd_rdy and overrun
//   overrun      sticky: a command completed while cmd_rdy was still high
//   frm_err      one-cycle pulse: partial command discarded on timeout
module uart_cmd_ctrl #(
    parameter int TIMEOUT_CYCLES = 100000,  // must be >= 2
    parameter int TO_W           = 17       // 2**TO_W > TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        overrun,
    output logic        frm_err
);

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_LO = 1'b1
    } state_t;

    // Last counter value before the partial command is dropped.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [7:0]      hi_byte;
    logic [TO_W-1:0] to_cnt;
    logic            rx_rdy_q;

    logic accept;
    logic complete;

    // A byte is taken only on the rising edge of rx_rdy, so a level held for
    // the whole UART stop bit yields one accept. rx_rdy_q resets low, which
    // makes a level already high at reset release count as a new byte.
    assign accept   = rx_rdy & ~rx_rdy_q;
    assign complete = (state == WAIT_LO) & accept;

    // NOTE: every register here is assigned with <= so all updates use the
    // values from before the clock edge; mixing in = would make the result
    // depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: all state, including the data registers cmd and hi_byte,
            // is reset; the block holds no memory array that would need to be
            // left unreset.
            state      <= IDLE;
            hi_byte    <= 8'h00;
            to_cnt     <= '0;
            rx_rdy_q   <= 1'b0;
            clr_rx_rdy <= 1'b0;
            cmd        <= 16'h0000;
            cmd_rdy    <= 1'b0;
            overrun    <= 1'b0;
            frm_err    <= 1'b0;
        end else begin
            rx_rdy_q   <= rx_rdy;
            clr_rx_rdy <= accept;
            frm_err    <= 1'b0;

            // Completion beats a coincident clear: the new command is valid.
            if (complete) begin
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end

            // A coincident clear wins over overrun: the consumer has just
            // read the previous command, so nothing was lost from its view.
            if (clr_cmd_rdy) begin
                overrun <= 1'b0;
            end else if (complete && cmd_rdy) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        hi_byte <= rx_data;
                        to_cnt  <= '0;
                        state   <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (accept) begin
                        // A byte arriving on the timeout cycle still completes.
                        cmd   <= {hi_byte, rx_data};
                        state <= IDLE;
                    end else if (to_cnt == TO_LAST) begin
                        frm_err <= 1'b1;
                        hi_byte <= 8'h00;
                        state   <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl
//   Directed scenarios followed by randomized byte traffic for uart_cmd_ctrl.
//   A transaction-level reference model (pending high byte plus its age in
//   cycles, held command, ready and overrun flags) predicts every output on
//   every clock; directed scenarios add fixed expected values on top.
module tb_uart_cmd_ctrl;

    localparam int TO   = 50;
    localparam int TO_W = 6;

    logic        clk;
    logic        rst_n;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        overrun;
    logic        frm_err;

    uart_cmd_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .TO_W          (TO_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .overrun    (overrun),
        .frm_err    (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int clr_pulses;
    int frm_pulses;

    // Reference model state.
    bit        m_prev_rx;   // rx_rdy level seen at the previous clock
    bit        m_have_hi;   // a high byte is waiting for its partner
    bit [7:0]  m_hi;
    int        m_age;       // cycles elapsed since the high byte arrived
    bit [15:0] m_cmd;
    bit        m_rdy;
    bit        m_ovr;
    bit        m_frm;
    bit        m_clr_rx;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_prev_rx = 0;
        m_have_hi = 0;
        m_hi      = 8'h00;
        m_age     = 0;
        m_cmd     = 16'h0000;
        m_rdy     = 0;
        m_ovr     = 0;
        m_frm     = 0;
        m_clr_rx  = 0;
    endfunction

    // Advance the model by one clock using the inputs present before the edge.
    function automatic void model_tick();
        bit        new_byte;
        bit        done;
        bit [15:0] word;
        new_byte  = rx_rdy && !m_prev_rx;
        m_prev_rx = rx_rdy;
        m_clr_rx  = new_byte;
        m_frm     = 0;
        done      = 0;
        word      = 16'h0000;
        if (new_byte) begin
            if (m_have_hi) begin
                word      = {m_hi, rx_data};
                done      = 1;
                m_have_hi = 0;
            end else begin
                m_hi      = rx_data;
                m_have_hi = 1;
                m_age     = 0;
            end
        end else if (m_have_hi) begin
            m_age++;
            if (m_age == TO) begin
                m_have_hi = 0;
                m_frm     = 1;
            end
        end
        if (clr_cmd_rdy)
            m_ovr = 0;
        else if (done && m_rdy)
            m_ovr = 1;
        if (done) begin
            m_cmd = word;
            m_rdy = 1;
        end else if (clr_cmd_rdy) begin
            m_rdy = 0;
        end
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_cmd"},     cmd,        m_cmd);
        check({tag, "_cmd_rdy"}, cmd_rdy,    16'(m_rdy));
        check({tag, "_overrun"}, overrun,    16'(m_ovr));
        check({tag, "_frm_err"}, frm_err,    16'(m_frm));
        check({tag, "_clr_rx"},  clr_rx_rdy, 16'(m_clr_rx));
    endtask

    // One clock: model first, then the DUT edge, then sample on the falling edge.
    task automatic step();
        model_tick();
        @(posedge clk);
        @(negedge clk);
        if (clr_rx_rdy) clr_pulses++;
        if (frm_err)    frm_pulses++;
        check_all("cyc");
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        rx_data = b;
        rx_rdy  = 1'b1;
        repeat (hold) step();
        rx_rdy = 1'b0;
        repeat (gap) step();
    endtask

    task automatic send_pair(input logic [15:0] w);
        send_byte(w[15:8], 1, 2);
        send_byte(w[7:0], 1, 2);
    endtask

    task automatic clr_pulse();
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        int hold;
        int gap;

        rst_n       = 1'b0;
        rx_rdy      = 1'b0;
        rx_data     = 8'h00;
        clr_cmd_rdy = 1'b0;
        clr_pulses  = 0;
        frm_pulses  = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        step();

        // Two long-held bytes form one command; one ack pulse per byte.
        clr_pulses = 0;
        frm_pulses = 0;
        send_byte(8'hA5, 30, 10);
        rx_data = 8'h3C;
        rx_rdy  = 1'b1;
        step();
        check("pair_cmd", cmd, 16'hA53C);
        check("pair_rdy", cmd_rdy, 16'd1);
        check("pair_ovr", overrun, 16'd0);
        repeat (29) step();
        rx_rdy = 1'b0;
        repeat (5) step();
        check("pair_ack_pulses", 16'(clr_pulses), 16'd2);
        check("pair_frm_pulses", 16'(frm_pulses), 16'd0);

        // Consumer acknowledge clears ready; the command value is held.
        clr_pulse();
        check("ack_rdy", cmd_rdy, 16'd0);
        check("ack_cmd_hold", cmd, 16'hA53C);

        // Lone high byte times out; the next pair is assembled cleanly.
        frm_pulses = 0;
        send_byte(8'h12, 1, TO + 5);
        check("timeout_frm_pulses", 16'(frm_pulses), 16'd1);
        send_pair(16'h3456);
        check("resync_cmd", cmd, 16'h3456);
        clr_pulse();

        // Second completion without acknowledge sets overrun.
        send_pair(16'h1111);
        send_pair(16'h2222);
        check("ovr_cmd", cmd, 16'h2222);
        check("ovr_rdy", cmd_rdy, 16'd1);
        check("ovr_flag", overrun, 16'd1);
        clr_pulse();
        check("ovr_clr_rdy", cmd_rdy, 16'd0);
        check("ovr_clr_flag", overrun, 16'd0);

        // Completion coincident with acknowledge: ready stays, no overrun.
        send_pair(16'h7777);
        send_byte(8'hAB, 1, 2);
        rx_data     = 8'hCD;
        rx_rdy      = 1'b1;
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        rx_rdy      = 1'b0;
        check("coinc_cmd", cmd, 16'hABCD);
        check("coinc_rdy", cmd_rdy, 16'd1);
        check("coinc_ovr", overrun, 16'd0);
        step();
        clr_pulse();

        // Low byte rising exactly on the timeout cycle completes the command.
        frm_pulses = 0;
        send_byte(8'h9A, 1, TO - 1);
        send_byte(8'hBC, 1, 2);
        check("edge_to_cmd", cmd, 16'h9ABC);
        check("edge_to_frm_pulses", 16'(frm_pulses), 16'd0);
        clr_pulse();

        // Reset while waiting for the low byte; rx_rdy stays high across release.
        rx_data = 8'hFF;
        rx_rdy  = 1'b1;
        step();
        #2 rst_n = 1'b0;
        rx_data = 8'h01;
        #1;
        check("mid_rst_cmd", cmd, 16'h0000);
        check("mid_rst_rdy", cmd_rdy, 16'd0);
        check("mid_rst_ovr", overrun, 16'd0);
        check("mid_rst_frm", frm_err, 16'd0);
        check("mid_rst_clr_rx", clr_rx_rdy, 16'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_ack", clr_rx_rdy, 16'd1);
        rx_rdy = 1'b0;
        step();
        send_byte(8'h02, 1, 2);
        check("post_rst_cmd", cmd, 16'h0102);
        check("post_rst_rdy", cmd_rdy, 16'd1);

        // Randomized traffic: varied holds, gaps near the timeout, random acks.
        for (int i = 0; i < 300; i++) begin
            rx_data = 8'($urandom);
            rx_rdy  = 1'b1;
            hold    = int'($urandom_range(1, 6));
            for (int k = 0; k < hold; k++) begin
                clr_cmd_rdy = ($urandom_range(0, 3) == 0);
                step();
            end
            rx_rdy = 1'b0;
            if ($urandom_range(0, 7) == 0)
                gap = int'($urandom_range(TO - 8, TO + 3));
            else
                gap = int'($urandom_range(1, 8));
            for (int k = 0; k < gap; k++) begin
                clr_cmd_rdy = ($urandom_range(0, 3) == 0);
                step();
            end
        end
        clr_cmd_rdy = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
